// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: sizes, state encoding
// and the rotating priority search.
package rr_arbiter4_pkg;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned ID_W         = 2;
  localparam int unsigned HOLD_MAX_DEF = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Returns the first requester set in the order last+1, last+2, last+3, last+4.
  // Scanning from the farthest candidate down lets the nearest one win.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] idx;
    rr_pick = last + 2'd1;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter4_decoder2to4.sv
// 2-to-4 one-hot decoder with enable; output is all zero when disabled.
module decoder2to4 (
  input  logic [1:0] idx_i,
  input  logic       en_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    onehot_o = 4'b0000;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time and a one-cycle
// idle bubble between consecutive grants.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);

  state_e            state_q;
  logic [ID_W-1:0]   gnt_id_q;
  logic              gnt_valid_q;
  logic [7:0]        hold_cnt_q;
  logic [ID_W-1:0]   last_id_q;

  logic [ID_W-1:0]   gnt_id_d;
  logic              any_req;
  logic              others_req;
  logic              owner_req;

  always_comb begin
    gnt_id_d   = rr_pick(req, last_id_q);
    any_req    = |req;
    owner_req  = req[gnt_id_q];
    others_req = |(req & ~(4'b0001 << gnt_id_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      last_id_q   <= 2'd3;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q     <= ST_GRANT;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= '0;
          end
        end
        ST_GRANT: begin
          // Voluntary release, or forced rotation once the hold budget is spent.
          if (!owner_req || (others_req && (hold_cnt_q >= HOLD_LAST))) begin
            state_q     <= ST_IDLE;
            gnt_valid_q <= 1'b0;
            last_id_q   <= gnt_id_q;
            hold_cnt_q  <= '0;
          end else if (hold_cnt_q < HOLD_SAT) begin
            hold_cnt_q  <= hold_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

  decoder2to4 u_gnt_dec (
    .idx_i    (gnt_id_q),
    .en_i     (gnt_valid_q),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios plus biased random traffic,
// compared cycle by cycle with a behavioural ownership model.
module tb_rr_arbiter4;

  localparam int HOLD = 15;
  localparam int MAX_WAIT = 3 * (HOLD + 1);

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int n_chk;
  int n_pass;

  // model: current owner (-1 = none), last owner, cycles held so far
  int m_owner;
  int m_last;
  int m_held;

  int wait_cnt [4];
  int max_wait;

  rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    bit others;
    if (m_owner >= 0) begin
      others = 1'b0;
      for (int i = 0; i < 4; i++) if (i != m_owner && r[i]) others = 1'b1;
      if (!r[m_owner] || (others && m_held >= HOLD)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++)
        if (m_owner < 0 && r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
      m_held = 1;
    end
  endtask

  function automatic logic [3:0] model_gnt();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // Drive req, take one clock edge, advance the model, then compare outputs.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    chk("gnt", {4'b0, gnt}, {4'b0, model_gnt()});
    chk("gnt_valid", {7'b0, gnt_valid}, {7'b0, (m_owner >= 0)});
    if (m_owner >= 0) chk("gnt_id", {6'b0, gnt_id}, 8'(m_owner));
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] cons;
    logic [3:0] r;
    n_chk    = 0;
    n_pass   = 0;
    max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    model_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #3;
    chk("rst_gnt", {4'b0, gnt}, 8'h00);
    chk("rst_valid", {7'b0, gnt_valid}, 8'h00);
    chk("rst_id", {6'b0, gnt_id}, 8'h00);
    #9 rst_n = 1'b1;

    // all requesting: rotation 0,1,2,3,0 with HOLD-cycle grants and 1-cycle gaps
    for (int i = 1; i <= 66; i++) begin
      step(4'b1111);
      exp_g = 4'b0000;
      if (((i - 1) % (HOLD + 1)) != HOLD) exp_g[((i - 1) / (HOLD + 1)) % 4] = 1'b1;
      chk("rotate", {4'b0, gnt}, {4'b0, exp_g});
    end
    step(4'b0000);
    step(4'b0000);

    // single request for three cycles
    for (int i = 0; i < 3; i++) begin
      step(4'b0100);
      chk("single_hold", {4'b0, gnt}, 8'h04);
    end
    step(4'b0000);
    chk("single_release", {4'b0, gnt}, 8'h00);

    // last owner 2: wrap-around favours requester 0 over 1
    step(4'b0011);
    chk("wrap", {4'b0, gnt}, 8'h01);
    step(4'b0000);
    step(4'b0000);

    // saturated hold persists until another request appears
    for (int i = 0; i < 40; i++) step(4'b0010);
    chk("persist", {4'b0, gnt}, 8'h02);
    step(4'b1010);
    chk("forced_release", {4'b0, gnt}, 8'h00);
    step(4'b1010);
    chk("after_bubble", {4'b0, gnt}, 8'h08);

    // asynchronous reset in the middle of a grant
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", {4'b0, gnt}, 8'h00);
    chk("async_valid", {7'b0, gnt_valid}, 8'h00);
    chk("async_id", {6'b0, gnt_id}, 8'h00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010);
    chk("post_reset", {4'b0, gnt}, 8'h02);
    step(4'b0000);
    step(4'b0000);

    // biased random traffic: each request bit flips with probability 1/16
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 15) == 0) r[i] = ~r[i];
      step(r);
      chk("onehot", {7'b0, $onehot0(gnt)}, 8'h01);
      cons = 4'b0000;
      if (gnt_valid) cons[gnt_id] = 1'b1;
      chk("consistent", {4'b0, gnt}, {4'b0, cons});
      for (int i = 0; i < 4; i++) begin
        if (!r[i] || gnt[i]) wait_cnt[i] = 0;
        else if (gnt_valid) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    chk("starvation", {7'b0, (max_wait <= MAX_WAIT)}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter HOLD_MAX, default 15, meaning: max consecutive grant cycles before forced rotation when others wait; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per requester; bit i = requester i wants the shared resource.
REQ-005 gnt  output  4  one-hot grant; at most one bit set.
REQ-006 gnt_id  output  2  binary index of current owner; valid only when gnt_valid=1.
REQ-007 gnt_valid  output  1  high while any grant is held.
REQ-008 All outputs SHALL be registered; no combinational path from req to any output.

Function
REQ-009 FSM SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-010 Arbiter SHALL keep a 2-bit last_id; search order = last_id+1, +2, +3, +4, all mod 4 (wrap 3->0).
REQ-011 IDLE, req != 0 at edge: next cycle gnt_id = first set req bit in search order, gnt = decode(gnt_id), gnt_valid = 1, state GRANT, hold_cnt = 0.
REQ-012 IDLE, req == 0: stay IDLE, outputs stay 0.
REQ-013 Grant latency SHALL be exactly 1 cycle from the first sampled request.
REQ-014 GRANT, req[gnt_id] = 0 at edge: release; next cycle gnt = 0, gnt_valid = 0, last_id = gnt_id, state IDLE.
REQ-015 After any release, IDLE SHALL last at least 1 cycle (one-cycle bubble) before the next grant.
REQ-016 GRANT, req[gnt_id] = 1: hold_cnt increments by 1 per cycle, saturating at HOLD_MAX.
REQ-017 GRANT, hold_cnt = HOLD_MAX-1, req[gnt_id] = 1, any other req bit set: forced release exactly as REQ-014.
REQ-018 GRANT, hold_cnt saturated, no other req set: grant SHALL persist indefinitely; forced release happens on the first edge another req is seen.
REQ-019 Requests from non-owners during GRANT SHALL NOT change gnt or gnt_id.
REQ-020 gnt SHALL equal the 2-to-4 decode of gnt_id when gnt_valid = 1 and 4'b0000 otherwise.
REQ-021 Simultaneous release and new requests SHALL follow REQ-014/REQ-015: release first, re-arbitrate in IDLE with updated last_id.
REQ-022 hold_cnt width SHALL be 8 bits.

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, hold_cnt = 0, last_id = 3 (requester 0 has first priority).
REQ-024 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-025 First arbitration after rst_n deassertion SHALL occur on the first rising edge with rst_n high.

Structure
REQ-026 Shared package SHALL hold: state encoding constants (IDLE = 0, GRANT = 1), requester count 4, id width 2, HOLD_MAX default.
REQ-027 One sub-module SHALL be instantiated: decoder2to4 (2-bit index plus enable in, 4-bit one-hot out), generating gnt from gnt_id and gnt_valid.
REQ-028 The priority search SHALL be combinational logic feeding the registered gnt_id; no other sub-modules.

Verification
REQ-029 Reset, then req = 4'b1111 held: grants SHALL rotate 0 -> 1 -> 2 -> 3 -> 0, each lasting HOLD_MAX = 15 cycles, with a 1-cycle gnt = 0 gap between grants.
REQ-030 req = 4'b0100 for 3 cycles, then 0: gnt = 4'b0100 for 3 cycles, starting 1 cycle after req rises; gnt = 0 one cycle after req falls.
REQ-031 last_id = 2, req = 4'b0011 in IDLE: gnt SHALL be 4'b0001 (wrap-around), not 4'b0010.
REQ-032 Owner 1 holds with no other req for 40 cycles: grant SHALL persist; raise req[3] at cycle 40: release SHALL occur at the next edge, then gnt = 4'b1000 after the bubble.
REQ-033 Pulse rst_n low mid-grant between clock edges: gnt, gnt_valid, gnt_id SHALL go 0 immediately; after release of reset, req = 4'b1010 SHALL yield gnt = 4'b0010.
REQ-034 Random req traffic, 10k cycles: gnt always one-hot or zero, always consistent with gnt_id/gnt_valid, and no requester held off more than 3*(HOLD_MAX+1) cycles while requesting.
